fp_wb_arbiter: RTL and testbench

- Completion-side counterpart of the FP busy-register scoreboard.
- Collects results from the multi-cycle and pipelined FP units (FMA pipe, div/sqrt, convert) and buffers one result per unit.
- Round-robin arbitrates the buffered results onto the single FP writeback port.
- Drives the writeback address/enable that clears scoreboard busy flags. Also exports each unit's pending rd for the scoreboard's in-use checks.

---
 rtl/fp_wb_pkg.sv | 21 ++
 rtl/fp_wb_arbiter_rr.sv | 44 ++++
 rtl/fp_wb_arbiter.sv | 98 +++++++++
 tb/tb_fp_wb_arbiter.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_wb_pkg.sv
// Shared types and constants for the FP writeback arbiter slice.
// Each execution unit owns one holding entry of type fp_wb_entry_t.
package fp_wb_pkg;

  localparam int unsigned FP_NUM_UNITS  = 3;
  localparam int unsigned FFLAGS_W      = 5;
  localparam int unsigned FP_DATA_W     = 32;
  localparam int unsigned FP_REG_ADDR_W = 5;

  localparam int unsigned FPU_FMA     = 0;
  localparam int unsigned FPU_DIVSQRT = 1;
  localparam int unsigned FPU_CVT     = 2;

  typedef struct packed {
    logic [FP_REG_ADDR_W-1:0] rd;
    logic [FP_DATA_W-1:0]     data;
    logic [FFLAGS_W-1:0]      fflags;
    logic                     is_int;
  } fp_wb_entry_t;

endpackage

// File: rtl/fp_wb_arbiter_rr.sv
// Round-robin arbiter: one-hot grant to the first request at or after rr_ptr.
// The pointer moves past the winner only on cycles where advance_i is high.
module rr_arbiter #(
  parameter  int unsigned NUM_REQ = 3,
  localparam int unsigned PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               advance_i,
  output logic [NUM_REQ-1:0] grant_o
);

  logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [PTR_W:0]   sum;
  logic [PTR_W-1:0] idx;
  logic             found;

  always_comb begin
    grant_o  = '0;
    rr_ptr_d = rr_ptr_q;
    found    = 1'b0;
    sum      = '0;
    idx      = '0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      // Rotated index (rr_ptr + off) mod NUM_REQ without a divider.
      sum = {1'b0, rr_ptr_q} + (PTR_W+1)'(off);
      if (sum >= (PTR_W+1)'(NUM_REQ)) sum = sum - (PTR_W+1)'(NUM_REQ);
      idx = sum[PTR_W-1:0];
      if (!found && req_i[idx]) begin
        found        = 1'b1;
        grant_o[idx] = 1'b1;
        rr_ptr_d     = (idx == PTR_W'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
      end
    end
    if (!advance_i) rr_ptr_d = rr_ptr_q;
  end

  always_ff @(posedge clk) begin
    if (reset) rr_ptr_q <= '0;
    else       rr_ptr_q <= rr_ptr_d;
  end

endmodule

// File: rtl/fp_wb_arbiter.sv
// FP writeback arbiter: one holding entry per execution unit, round-robin
// drained onto the single writeback port; no combinational unit->wb path.
module fp_wb_arbiter #(
  parameter  int unsigned NUM_UNITS  = fp_wb_pkg::FP_NUM_UNITS,
  parameter  int unsigned DATA_W     = fp_wb_pkg::FP_DATA_W,
  parameter  int unsigned REG_ADDR_W = fp_wb_pkg::FP_REG_ADDR_W,
  parameter  int unsigned FFLAGS_W   = fp_wb_pkg::FFLAGS_W,
  localparam int unsigned UNIT_W     = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [NUM_UNITS-1:0]                 unit_valid,
  output logic [NUM_UNITS-1:0]                 unit_ready,
  input  logic [NUM_UNITS-1:0][REG_ADDR_W-1:0] unit_rd,
  input  logic [NUM_UNITS-1:0][DATA_W-1:0]     unit_data,
  input  logic [NUM_UNITS-1:0][FFLAGS_W-1:0]   unit_fflags,
  input  logic [NUM_UNITS-1:0]                 unit_rd_is_int,
  input  logic                                 wb_stall,
  output logic                                 wb_fp_write,
  output logic                                 wb_int_write,
  output logic [REG_ADDR_W-1:0]                wb_rd,
  output logic [DATA_W-1:0]                    wb_data,
  output logic [FFLAGS_W-1:0]                  wb_fflags,
  output logic [UNIT_W-1:0]                    wb_unit,
  output logic [NUM_UNITS-1:0]                 pending_valid,
  output logic [NUM_UNITS-1:0][REG_ADDR_W-1:0] pending_rd,
  output logic                                 busy
);

  import fp_wb_pkg::*;

  logic [NUM_UNITS-1:0] hold_valid_q, hold_valid_d;
  fp_wb_entry_t         hold_q [NUM_UNITS];
  fp_wb_entry_t         hold_d [NUM_UNITS];
  logic [NUM_UNITS-1:0] req, grant, accept;

  // Stall masks every request so neither the grant nor the pointer moves.
  assign req = wb_stall ? '0 : hold_valid_q;

  rr_arbiter #(.NUM_REQ(NUM_UNITS)) u_rr (
    .clk       (clk),
    .reset     (reset),
    .req_i     (req),
    .advance_i (|grant),
    .grant_o   (grant)
  );

  assign unit_ready = ~hold_valid_q | grant;
  assign accept     = unit_valid & unit_ready;

  always_comb begin
    hold_valid_d = (hold_valid_q & ~grant) | accept;
    for (int unsigned i = 0; i < NUM_UNITS; i++) begin
      hold_d[i] = hold_q[i];
      if (accept[i]) begin
        hold_d[i] = '{rd: unit_rd[i], data: unit_data[i],
                      fflags: unit_fflags[i], is_int: unit_rd_is_int[i]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_valid_q <= '0;
      for (int unsigned i = 0; i < NUM_UNITS; i++) hold_q[i] <= '0;
    end else begin
      hold_valid_q <= hold_valid_d;
      for (int unsigned i = 0; i < NUM_UNITS; i++) hold_q[i] <= hold_d[i];
    end
  end

  always_comb begin
    wb_fp_write  = 1'b0;
    wb_int_write = 1'b0;
    wb_rd        = '0;
    wb_data      = '0;
    wb_fflags    = '0;
    wb_unit      = '0;
    for (int unsigned i = 0; i < NUM_UNITS; i++) begin
      if (grant[i]) begin
        wb_fp_write  = ~hold_q[i].is_int;
        wb_int_write = hold_q[i].is_int;
        wb_rd        = hold_q[i].rd;
        wb_data      = hold_q[i].data;
        wb_fflags    = hold_q[i].fflags;
        wb_unit      = UNIT_W'(i);
      end
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NUM_UNITS; i++) pending_rd[i] = hold_q[i].rd;
  end

  assign pending_valid = hold_valid_q;
  assign busy          = (|hold_valid_q) | (|unit_valid);

endmodule

// File: tb/tb_fp_wb_arbiter.sv
// Directed bench for fp_wb_arbiter: hand-computed expectations checked with
// immediate assertions after each step.
module tb_fp_wb_arbiter;
  import fp_wb_pkg::*;

  logic             clk = 1'b0;
  logic             reset;
  logic [2:0]       unit_valid, unit_ready, unit_rd_is_int, pending_valid;
  logic [2:0][4:0]  unit_rd, pending_rd, unit_fflags;
  logic [2:0][31:0] unit_data;
  logic             wb_stall, wb_fp_write, wb_int_write, busy;
  logic [4:0]       wb_rd, wb_fflags;
  logic [31:0]      wb_data;
  logic [1:0]       wb_unit;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_hold [3];

  fp_wb_arbiter #(
    .NUM_UNITS(3), .DATA_W(32), .REG_ADDR_W(5), .FFLAGS_W(5)
  ) dut (
    .clk(clk), .reset(reset),
    .unit_valid(unit_valid), .unit_ready(unit_ready),
    .unit_rd(unit_rd), .unit_data(unit_data), .unit_fflags(unit_fflags),
    .unit_rd_is_int(unit_rd_is_int), .wb_stall(wb_stall),
    .wb_fp_write(wb_fp_write), .wb_int_write(wb_int_write),
    .wb_rd(wb_rd), .wb_data(wb_data), .wb_fflags(wb_fflags), .wb_unit(wb_unit),
    .pending_valid(pending_valid), .pending_rd(pending_rd), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic waw_check();
    for (int i = 0; i < 3; i++)
      for (int j = i + 1; j < 3; j++)
        if (pending_valid[i] && pending_valid[j]) begin
          checks++;
          assert (pending_rd[i] !== pending_rd[j]) else begin
            errors++;
            $error("FAIL waw_rd entries %0d/%0d observed=%0h expected=distinct", i, j, pending_rd[i]);
          end
        end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    waw_check();
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive(input int u, input logic v, input logic [4:0] rd,
                       input logic [31:0] d, input logic [4:0] ff, input logic isint);
    unit_valid[u]     = v;
    unit_rd[u]        = rd;
    unit_data[u]      = d;
    unit_fflags[u]    = ff;
    unit_rd_is_int[u] = isint;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_fp_write"},  64'(wb_fp_write),  64'd0);
    chk({tag, "_int_write"}, 64'(wb_int_write), 64'd0);
    chk({tag, "_rd"},        64'(wb_rd),        64'd0);
    chk({tag, "_data"},      64'(wb_data),      64'd0);
    chk({tag, "_fflags"},    64'(wb_fflags),    64'd0);
  endtask

  task automatic chk_grant(input string tag, input int u, input logic [4:0] rd,
                           input logic [31:0] d);
    chk({tag, "_unit"},     64'(wb_unit),     64'(u));
    chk({tag, "_rd"},       64'(wb_rd),       64'(rd));
    chk({tag, "_data"},     64'(wb_data),     64'(d));
    chk({tag, "_fp_write"}, 64'(wb_fp_write), 64'd1);
    chk({tag, "_int_wr"},   64'(wb_int_write),64'd0);
  endtask

  initial begin
    // Reset with all units presenting results.
    reset = 1'b1; wb_stall = 1'b0;
    drive(0, 1'b1, 5'd1, 32'hA000_0000, 5'd0, 1'b0);
    drive(1, 1'b1, 5'd2, 32'hA000_0001, 5'd0, 1'b0);
    drive(2, 1'b1, 5'd3, 32'hA000_0002, 5'd0, 1'b0);
    tick();
    tick();
    reset = 1'b0;
    settle();
    chk("rst_ready",   64'(unit_ready),    64'h7);
    chk("rst_pending", 64'(pending_valid), 64'h0);
    chk_idle("rst");
    tick();
    chk_grant("rst_first", 0, 5'd1, 32'hA000_0000);
    chk("rst_first_ready", 64'(unit_ready), 64'h1);
    unit_valid = 3'b000;
    tick();
    chk_grant("rst_second", 1, 5'd2, 32'hA000_0001);
    tick();
    chk_grant("rst_third", 2, 5'd3, 32'hA000_0002);
    tick();
    chk_idle("drained");
    chk("drained_busy", 64'(busy), 64'd0);

    // Unit 1 alone; result must not appear before the accepting edge.
    drive(1, 1'b1, 5'd5, 32'h3F80_0000, 5'b00001, 1'b0);
    settle();
    chk("u1_no_comb_path", 64'(wb_fp_write), 64'd0);
    chk("u1_busy", 64'(busy), 64'd1);
    tick();
    unit_valid = 3'b000;
    settle();
    chk_grant("u1", 1, 5'd5, 32'h3F80_0000);
    chk("u1_fflags",  64'(wb_fflags),     64'd1);
    chk("u1_pending", 64'(pending_valid), 64'h2);
    tick();
    chk_idle("u1_after");

    // Fresh pointer, then all units valid every cycle.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(i, 1'b1, 5'(7 + i), 32'hC000_0000 + 32'(i), 5'(i), 1'b0);
      exp_hold[i] = unit_data[i];
    end
    tick();
    for (int i = 0; i < 3; i++) unit_data[i] = 32'hD000_0000 + 32'(i);
    for (int k = 0; k < 6; k++) begin
      settle();
      chk_grant($sformatf("stream%0d", k), k % 3, 5'(7 + k % 3), exp_hold[k % 3]);
      chk($sformatf("stream%0d_ready", k), 64'(unit_ready), 64'(1 << (k % 3)));
      exp_hold[k % 3] = unit_data[k % 3];
      tick();
      unit_data[k % 3] = 32'hC000_0000 + 32'((k + 1) * 16) + 32'(k % 3);
    end
    unit_valid = 3'b000;
    for (int k = 6; k < 9; k++) begin
      settle();
      chk_grant($sformatf("stream_drain%0d", k), k % 3, 5'(7 + k % 3), exp_hold[k % 3]);
      tick();
    end
    chk("stream_empty", 64'(pending_valid), 64'h0);

    // Entries 0 and 2 held across a 4-cycle stall.
    drive(0, 1'b1, 5'd11, 32'h1111_0000, 5'b00100, 1'b0);
    drive(2, 1'b1, 5'd13, 32'h1313_0000, 5'b01000, 1'b0);
    tick();
    unit_valid = 3'b000;
    wb_stall   = 1'b1;
    for (int s = 0; s < 4; s++) begin
      settle();
      chk_idle($sformatf("stall%0d", s));
      chk($sformatf("stall%0d_ready", s),   64'(unit_ready),    64'h2);
      chk($sformatf("stall%0d_pending", s), 64'(pending_valid), 64'h5);
      tick();
    end
    wb_stall = 1'b0;
    settle();
    chk_grant("release0", 0, 5'd11, 32'h1111_0000);
    chk("release0_fflags", 64'(wb_fflags), 64'h4);
    tick();
    chk_grant("release2", 2, 5'd13, 32'h1313_0000);
    tick();
    chk_idle("release_done");

    // All entries full under stall: nothing ready.
    drive(0, 1'b1, 5'd14, 32'h0E0E_0000, 5'd0, 1'b0);
    drive(1, 1'b1, 5'd15, 32'h0F0F_0000, 5'd0, 1'b0);
    drive(2, 1'b1, 5'd16, 32'h1010_0000, 5'd0, 1'b0);
    tick();
    wb_stall = 1'b1;
    settle();
    chk("full_ready", 64'(unit_ready), 64'h0);
    tick();
    chk("full_ready_hold", 64'(unit_ready),    64'h0);
    chk("full_pending",    64'(pending_valid), 64'h7);
    unit_valid = 3'b000;
    wb_stall   = 1'b0;
    settle();
    chk_grant("full0", 0, 5'd14, 32'h0E0E_0000);
    tick();
    chk_grant("full1", 1, 5'd15, 32'h0F0F_0000);
    tick();
    chk_grant("full2", 2, 5'd16, 32'h1010_0000);
    tick();
    chk_idle("full_done");

    // Integer-destination result from the convert unit.
    drive(FPU_CVT, 1'b1, 5'd10, 32'h0000_0001, 5'b10000, 1'b1);
    settle();
    chk("int_pre_pending", 64'(pending_valid), 64'h0);
    chk("int_pre_write",   64'(wb_int_write),  64'd0);
    tick();
    unit_valid = 3'b000;
    settle();
    chk("int_pending_v",  64'(pending_valid[2]), 64'd1);
    chk("int_pending_rd", 64'(pending_rd[2]),    64'd10);
    chk("int_int_write",  64'(wb_int_write),     64'd1);
    chk("int_fp_write",   64'(wb_fp_write),      64'd0);
    chk("int_rd",         64'(wb_rd),            64'd10);
    chk("int_unit",       64'(wb_unit),          64'd2);
    chk("int_fflags",     64'(wb_fflags),        64'h10);
    tick();
    chk("int_cleared", 64'(pending_valid), 64'h0);

    // Reset discards held results.
    drive(0, 1'b1, 5'd20, 32'h2020_0000, 5'd0, 1'b0);
    drive(1, 1'b1, 5'd21, 32'h2121_0000, 5'd0, 1'b0);
    wb_stall = 1'b1;
    tick();
    unit_valid = 3'b000;
    settle();
    chk("flush_held", 64'(pending_valid), 64'h3);
    reset = 1'b1;
    tick();
    reset    = 1'b0;
    wb_stall = 1'b0;
    settle();
    chk("flush_pending", 64'(pending_valid), 64'h0);
    chk("flush_busy",    64'(busy),          64'd0);
    chk_idle("flush");
    for (int c = 0; c < 3; c++) begin
      tick();
      chk_idle($sformatf("flush_after%0d", c));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
